// File: rtl/nibble_pkg.sv
// nibble_pkg: constants and FSM state encoding shared by the nibble-serial
// adder and its per-nibble add stage.
package nibble_pkg;

   localparam int NIBBLE_W      = 4;
   localparam int N_NIBBLES_DEF = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ADD  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: combinational 4-bit ripple-carry adder. The serial adder
// reuses this single instance once per nibble.
module nibble_add4
   import nibble_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic c;

   // Ripple the carry from bit 0 upward, one full adder per bit.
   always_comb begin
      sum = '0;
      c   = cin;
      for (int i = 0; i < NIBBLE_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two N_NIBBLES*4-bit operands one nibble per
// clock, LSB nibble first, using a single shared 4-bit adder.
// Optional feature: define NIBBLE_SERIAL_ADDER_OVF_EN to add a signed
// overflow output, loaded in DONE and cleared by reset and accepted start.
module nibble_serial_adder
   import nibble_pkg::*;
#(
   parameter int N_NIBBLES = N_NIBBLES_DEF
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [NIBBLE_W*N_NIBBLES-1:0] a,
   input  logic [NIBBLE_W*N_NIBBLES-1:0] b,
   input  logic                          carry_in,
   output logic                          busy,
   output logic                          done,
   output logic [NIBBLE_W*N_NIBBLES-1:0] sum,
   output logic                          carry_out
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   ,
   output logic                          overflow
`endif
);

   localparam int W     = NIBBLE_W * N_NIBBLES;
   localparam int IDX_W = $clog2(N_NIBBLES);

   state_t                state_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  carry_q;
   logic [W-1:0]          a_q;
   logic [W-1:0]          b_q;
   logic [NIBBLE_W-1:0]   a_nib;
   logic [NIBBLE_W-1:0]   b_nib;
   logic [NIBBLE_W-1:0]   nib_sum;
   logic                  nib_cout;
   logic                  last_nib;

   // Pick the current nibble of each captured operand for the shared adder.
   always_comb begin
      a_nib    = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
      b_nib    = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
      last_nib = (idx_q == IDX_W'(N_NIBBLES - 1));
   end

   nibble_add4 u_add (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry_q),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   // Status outputs decode directly from the state register.
   always_comb begin
      busy = (state_q != ST_IDLE);
      done = (state_q == ST_DONE);
   end

   // Sequencer: capture operands on start, add one nibble per ADD cycle,
   // publish the final carry, then spend one cycle in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_q       <= a;
                  b_q       <= b;
                  carry_q   <= carry_in;
                  sum       <= '0;
                  carry_out <= 1'b0;
                  idx_q     <= '0;
                  state_q   <= ST_ADD;
               end
            end
            ST_ADD: begin
               sum[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_sum;
               carry_q <= nib_cout;
               idx_q   <= idx_q + 1'b1;
               if (last_nib) begin
                  carry_out <= nib_cout;
                  state_q   <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   // Signed overflow: like-signed operands whose final sum flips sign.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (state_q == ST_IDLE && start) begin
         overflow <= 1'b0;
      end else if (state_q == ST_DONE) begin
         overflow <= (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
      end
   end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for the
// nibble-serial adder at N_NIBBLES=4. Define NIBBLE_SERIAL_ADDER_OVF_EN
// to also exercise the overflow output.
module tb_nibble_serial_adder;

   localparam int NN = 4;
   localparam int W  = 4 * NN;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry_out;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic         overflow;
`endif

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int start_cyc  = 0;

   nibble_serial_adder #(.N_NIBBLES(NN)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ,
      .overflow  (overflow)
`endif
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges so latencies can be measured.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Present operands with start for exactly one accepting edge.
   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic cv);
      @(negedge clk);
      a        = av;
      b        = bv;
      carry_in = cv;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      start     = 1'b0;
   endtask

   // Wait, bounded, for the done pulse; report the edge count it was seen at.
   task automatic waitDone(input string tag, output int done_cyc);
      bit seen;
      seen     = 1'b0;
      done_cyc = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen     = 1'b1;
            done_cyc = cyc;
         end
      end
      checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   // One full addition: latency, result, pulse width and result hold.
   task automatic runOp(input string tag, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
      int dc;
      applyStimulus(av, bv, cv);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      waitDone(tag, dc);
      checkOutput({tag, "_latency"}, 32'(dc - start_cyc + 1), 32'(NN + 1));
      checkOutput({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      checkOutput({tag, "_cout"}, 32'(carry_out), 32'(exp_cout));
      @(negedge clk);
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
   endtask

   // Directed test sequence.
   initial begin
      int d1, d2, d3;
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      carry_in = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_sum", 32'(sum), 32'd0);
      checkOutput("rst_cout", 32'(carry_out), 32'd0);
      rst = 1'b0;

      runOp("t00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
      runOp("tffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      runOp("t1234", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);

      // start during the second ADD cycle must not disturb the operation
      applyStimulus(16'h1111, 16'h2222, 1'b0);
      @(posedge clk);
      #2;
      a     = 16'hAAAA;
      b     = 16'hAAAA;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      waitDone("ign", d1);
      checkOutput("ign_latency", 32'(d1 - start_cyc + 1), 32'(NN + 1));
      checkOutput("ign_sum", 32'(sum), 32'h3333);
      checkOutput("ign_cout", 32'(carry_out), 32'd0);

      // reset during the second ADD cycle clears outputs without a clock
      applyStimulus(16'h1234, 16'h1111, 1'b0);
      @(posedge clk);
      #2;
      checkOutput("mid_partial_sum", 32'(sum), 32'h0005);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_done", 32'(done), 32'd0);
      checkOutput("mid_rst_sum", 32'(sum), 32'd0);
      checkOutput("mid_rst_cout", 32'(carry_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      runOp("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

      // start held high: back-to-back operations every NN+2 cycles
      @(negedge clk);
      a        = 16'h0101;
      b        = 16'h0202;
      carry_in = 1'b0;
      start    = 1'b1;
      waitDone("hold1", d1);
      checkOutput("hold1_sum", 32'(sum), 32'h0303);
      checkOutput("hold1_cout", 32'(carry_out), 32'd0);
      a        = 16'h8000;
      b        = 16'h8000;
      waitDone("hold2", d2);
      checkOutput("hold2_sum", 32'(sum), 32'h0000);
      checkOutput("hold2_cout", 32'(carry_out), 32'd1);
      checkOutput("hold2_spacing", 32'(d2 - d1), 32'(NN + 2));
      a        = 16'h0FFF;
      b        = 16'h0001;
      carry_in = 1'b1;
      waitDone("hold3", d3);
      checkOutput("hold3_sum", 32'(sum), 32'h1001);
      checkOutput("hold3_cout", 32'(carry_out), 32'd0);
      checkOutput("hold3_spacing", 32'(d3 - d2), 32'(NN + 2));
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      runOp("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
      checkOutput("ovf_pos_flag", 32'(overflow), 32'd1);
      runOp("ovf_neg", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      checkOutput("ovf_neg_flag", 32'(overflow), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter N_NIBBLES, default 4, number of 4-bit nibbles per operand (minimum 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  4*N_NIBBLES  operand A, captured at accepted start.
REQ-006 SHALL have port b  input  4*N_NIBBLES  operand B, captured at accepted start.
REQ-007 SHALL have port carry_in  input  1  initial carry, captured at accepted start.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking a valid result.
REQ-010 SHALL have port sum  output  4*N_NIBBLES  registered result, modulo 2^(4*N_NIBBLES).
REQ-011 SHALL have port carry_out  output  1  registered final carry.

Function
REQ-012 SHALL implement the FSM states IDLE, ADD and DONE.
REQ-013 IDLE, start=1: SHALL capture a, b and carry_in, clear sum, clear carry_out, set nibble index to 0 and go to ADD; start=0: SHALL stay in IDLE.
REQ-014 ADD: each cycle SHALL add nibble[idx] of A and B plus the carry register, write sum nibble[idx] and update the carry register, then increment idx.
REQ-015 ADD SHALL last exactly N_NIBBLES cycles, LSB nibble first; after the cycle with idx=N_NIBBLES-1 it SHALL go to DONE and load carry_out.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-017 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+N_NIBBLES (N_NIBBLES+1 cycles after acceptance).
REQ-018 start while busy=1 SHALL be ignored; captured operands SHALL NOT change.
REQ-019 start held high continuously SHALL start a new operation in the first IDLE cycle after DONE, so throughput is one result per N_NIBBLES+2 cycles.
REQ-020 sum and carry_out SHALL hold their DONE values until the next start is accepted.
REQ-021 Wrap-around: any carry out of the MSB nibble SHALL appear only on carry_out; sum SHALL wrap.

Reset
REQ-022 rst=1 SHALL force, asynchronously, state=IDLE, idx=0, carry register=0, busy=0, done=0, sum=0 and carry_out=0.
REQ-023 rst asserted mid-operation SHALL discard the in-flight operation; the first start after release SHALL behave as from power-up.

Configuration
REQ-024 Macro NIBBLE_SERIAL_ADDER_OVF_EN defined: SHALL add output port overflow (1 bit), loaded in DONE as (A_msb==B_msb)&&(sum_msb!=A_msb), cleared by reset and by accepted start.
REQ-025 Macro undefined: the overflow port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 The shared package nibble_pkg SHALL hold the FSM state typedef, NIBBLE_W=4 and the N_NIBBLES default constant.
REQ-027 The per-cycle add SHALL be one combinational sub-module, nibble_add4 (4-bit ripple-carry sum/carry), instantiated once and reused every cycle.

Verification (N_NIBBLES=4)
REQ-028 a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, carry_out=0, done high exactly 5 cycles after the start edge.
REQ-029 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry_out=1; a=0x1234, b=0x4321, cin=1 -> sum=0x5556, carry_out=0.
REQ-030 start pulsed in the 2nd ADD cycle with a=0xAAAA -> ignored; result is still from the first operands.
REQ-031 rst asserted during the 2nd ADD cycle -> busy, done, sum and carry_out go to 0 without a clock; the next start gives the correct result.
REQ-032 start held high for 3 operations -> done pulses at 6-cycle spacing with correct results each time.
REQ-033 With the macro defined, a=0x7FFF, b=0x0001 -> overflow=1 and a=0xFFFF, b=0x0001 -> overflow=0; without the macro, port overflow is absent.
